sargantana_icache_refill: RTL and testbench

Refill engine directly upstream of the instruction-cache set RAMs. On a miss it issues one line request to the L2, assembles the returned beats into a full line, and writes that line into the victim way's set RAM in a single req/we cycle. It is the only writer of the set RAMs. The fetch lookup path reads those RAMs only while this block is idle.

---
 rtl/sargantana_icache_pkg.sv | 32 +++
 rtl/sargantana_refill_linebuf.sv | 52 +++++
 rtl/sargantana_icache_refill.sv | 198 +++++++++++++++++++
 tb/tb_sargantana_icache_refill.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sargantana_icache_pkg.sv
// sargantana_icache_pkg: shared types and constants for the I-cache refill engine.
// Default geometry: 256-bit lines, 64-bit L2 beats, 64 sets, 4 ways.
package sargantana_icache_pkg;

  localparam int unsigned DEF_LINE_WIDTH = 256;
  localparam int unsigned DEF_BEAT_WIDTH = 64;
  localparam int unsigned DEF_ADDR_WIDTH = 6;
  localparam int unsigned DEF_N_WAYS     = 4;

  localparam int unsigned NBEATS = DEF_LINE_WIDTH / DEF_BEAT_WIDTH;

  typedef logic [DEF_LINE_WIDTH-1:0] line_t;
  typedef logic [DEF_BEAT_WIDTH-1:0] beat_t;
  typedef logic [DEF_ADDR_WIDTH-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } refill_state_t;

  // Beat counter width; a single-beat line still gets a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned nbeats);
    if (nbeats > 32'd1) begin
      return $clog2(nbeats);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/sargantana_refill_linebuf.sv
// sargantana_refill_linebuf: line assembly register. Beat k lands in
// bits [k*BEAT_WIDTH +: BEAT_WIDTH]; clr_i wipes the whole line.
module sargantana_refill_linebuf
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int unsigned BEAT_WIDTH = DEF_BEAT_WIDTH,
  localparam int unsigned NB    = LINE_WIDTH / BEAT_WIDTH,
  localparam int unsigned CNT_W = cnt_width(NB)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  we_i,
  input  logic [CNT_W-1:0]      idx_i,
  input  logic [BEAT_WIDTH-1:0] data_i,
  output logic [LINE_WIDTH-1:0] line_o
);

  logic [LINE_WIDTH-1:0] line_q;
  logic [LINE_WIDTH-1:0] line_d;

  // Next line value: clear, write one beat slot, or hold.
  always_comb begin
    line_d = line_q;
    if (clr_i) begin
      line_d = '0;
    end else if (we_i) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (idx_i == CNT_W'(k)) begin
          line_d[k*BEAT_WIDTH +: BEAT_WIDTH] = data_i;
        end else begin
          line_d[k*BEAT_WIDTH +: BEAT_WIDTH] = line_q[k*BEAT_WIDTH +: BEAT_WIDTH];
        end
      end
    end else begin
      line_d = line_q;
    end
  end

  // Line storage register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/sargantana_icache_refill.sv
// sargantana_icache_refill: I-cache miss refill engine. Requests one line from
// L2, assembles the returned beats and writes the line into the victim way's
// set RAM in a single cycle. It is the sole writer of the set RAMs.
// Optional macro SARGANTANA_ICACHE_REFILL_FWD_EN adds fwd_valid_o/fwd_line_o,
// which forward the written line to fetch in the write cycle.
module sargantana_icache_refill
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int unsigned BEAT_WIDTH = DEF_BEAT_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned N_WAYS     = DEF_N_WAYS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  miss_i,
  input  logic [ADDR_WIDTH-1:0] miss_idx_i,
  input  logic [N_WAYS-1:0]     miss_way_i,
  input  logic                  kill_i,
  output logic                  busy_o,
  output logic                  l2_req_valid_o,
  output logic [ADDR_WIDTH-1:0] l2_req_idx_o,
  input  logic                  l2_req_ready_i,
  input  logic                  beat_valid_i,
  input  logic [BEAT_WIDTH-1:0] beat_data_i,
  input  logic                  beat_err_i,
  output logic [N_WAYS-1:0]     ram_req_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [LINE_WIDTH-1:0] ram_data_o,
  output logic                  done_o,
`ifdef SARGANTANA_ICACHE_REFILL_FWD_EN
  output logic                  fwd_valid_o,
  output logic [LINE_WIDTH-1:0] fwd_line_o,
`endif
  output logic                  err_o
);

  localparam int unsigned NB    = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CNT_W = cnt_width(NB);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NB - 32'd1);

  refill_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q,   idx_d;
  logic [N_WAYS-1:0]     way_q,   way_d;
  logic                  kill_q,  kill_d;
  logic                  err_q,   err_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;

  logic                  lb_clr_s;
  logic                  lb_we_s;
  logic [LINE_WIDTH-1:0] line_s;
  logic                  wr_en_s;

  sargantana_refill_linebuf #(
    .LINE_WIDTH (LINE_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_linebuf (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (lb_clr_s),
    .we_i   (lb_we_s),
    .idx_i  (cnt_q),
    .data_i (beat_data_i),
    .line_o (line_s)
  );

  // Next-state logic: miss capture, L2 handshake, beat collection, write.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    way_d    = way_q;
    kill_d   = kill_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    lb_clr_s = 1'b0;
    lb_we_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_i) begin
          idx_d    = miss_idx_i;
          way_d    = miss_way_i;
          kill_d   = 1'b0;
          err_d    = 1'b0;
          cnt_d    = '0;
          lb_clr_s = 1'b1;
          state_d  = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // A kill only marks the refill; the handshake must still finish.
        if (kill_i) begin
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
        if (l2_req_ready_i) begin
          state_d = FILL;
        end else begin
          state_d = REQ;
        end
      end
      FILL: begin
        if (kill_i) begin
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
        if (beat_valid_i) begin
          lb_we_s = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (beat_err_i) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (cnt_q == LAST_BEAT) begin
            state_d = WRITE;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      WRITE: begin
        if (kill_i) begin
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and context registers, synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      way_q   <= '0;
      kill_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      way_q   <= way_d;
      kill_q  <= kill_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode; a kill in the write cycle itself still blocks the write.
  always_comb begin
    wr_en_s        = (state_q == WRITE) && !kill_q && !err_q && !kill_i;
    busy_o         = (state_q != IDLE);
    l2_req_valid_o = (state_q == REQ);
    if (state_q == REQ) begin
      l2_req_idx_o = idx_q;
    end else begin
      l2_req_idx_o = '0;
    end
    if (wr_en_s) begin
      ram_req_o  = way_q;
      ram_we_o   = 1'b1;
      ram_addr_o = idx_q;
      ram_data_o = line_s;
    end else begin
      ram_req_o  = '0;
      ram_we_o   = 1'b0;
      ram_addr_o = '0;
      ram_data_o = '0;
    end
    done_o = wr_en_s;
    err_o  = (state_q == WRITE) && err_q;
  end

`ifdef SARGANTANA_ICACHE_REFILL_FWD_EN
  // Forward the freshly written line straight to fetch.
  always_comb begin
    fwd_valid_o = wr_en_s;
    if (wr_en_s) begin
      fwd_line_o = line_s;
    end else begin
      fwd_line_o = '0;
    end
  end
`endif

endmodule

// File: tb/tb_sargantana_icache_refill.sv
// tb_sargantana_icache_refill: directed bench for the I-cache refill engine.
module tb_sargantana_icache_refill;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         miss_i;
  logic [5:0]   miss_idx_i;
  logic [3:0]   miss_way_i;
  logic         kill_i;
  logic         busy_o;
  logic         l2_req_valid_o;
  logic [5:0]   l2_req_idx_o;
  logic         l2_req_ready_i;
  logic         beat_valid_i;
  logic [63:0]  beat_data_i;
  logic         beat_err_i;
  logic [3:0]   ram_req_o;
  logic         ram_we_o;
  logic [5:0]   ram_addr_o;
  logic [255:0] ram_data_o;
  logic         done_o;
  logic         err_o;
`ifdef SARGANTANA_ICACHE_REFILL_FWD_EN
  logic         fwd_valid_o;
  logic [255:0] fwd_line_o;
`endif

  int tests = 0;
  int fails = 0;
  logic [255:0] exp_line;

  always #5 clk_i = ~clk_i;

  sargantana_icache_refill dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .miss_i         (miss_i),
    .miss_idx_i     (miss_idx_i),
    .miss_way_i     (miss_way_i),
    .kill_i         (kill_i),
    .busy_o         (busy_o),
    .l2_req_valid_o (l2_req_valid_o),
    .l2_req_idx_o   (l2_req_idx_o),
    .l2_req_ready_i (l2_req_ready_i),
    .beat_valid_i   (beat_valid_i),
    .beat_data_i    (beat_data_i),
    .beat_err_i     (beat_err_i),
    .ram_req_o      (ram_req_o),
    .ram_we_o       (ram_we_o),
    .ram_addr_o     (ram_addr_o),
    .ram_data_o     (ram_data_o),
    .done_o         (done_o),
`ifdef SARGANTANA_ICACHE_REFILL_FWD_EN
    .fwd_valid_o    (fwd_valid_o),
    .fwd_line_o     (fwd_line_o),
`endif
    .err_o          (err_o)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs driven afterwards apply at the next edge.
  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic beat(input logic [63:0] d, input logic e);
    beat_valid_i = 1'b1;
    beat_data_i  = d;
    beat_err_i   = e;
    cyc();
    beat_valid_i = 1'b0;
    beat_err_i   = 1'b0;
  endtask

  task automatic start_miss(input logic [5:0] idx, input logic [3:0] way);
    miss_i     = 1'b1;
    miss_idx_i = idx;
    miss_way_i = way;
    cyc();
    miss_i     = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 256'(busy_o), 256'd0);
    chk({tag, "_req"},  256'(ram_req_o), 256'd0);
    chk({tag, "_done"}, 256'(done_o), 256'd0);
    chk({tag, "_err"},  256'(err_o), 256'd0);
  endtask

  initial begin
    rst_i = 1'b1; miss_i = 1'b0; miss_idx_i = 6'd0; miss_way_i = 4'd0; kill_i = 1'b0;
    l2_req_ready_i = 1'b0; beat_valid_i = 1'b0; beat_data_i = 64'd0; beat_err_i = 1'b0;
    cyc(); cyc();
    rst_i = 1'b0;

    // Reset state
    chk_quiet("rst");
    chk("rst_l2v",  256'(l2_req_valid_o), 256'd0);
    chk("rst_we",   256'(ram_we_o), 256'd0);
    chk("rst_addr", 256'(ram_addr_o), 256'd0);
    chk("rst_data", ram_data_o, 256'd0);

    // Basic refill, with a junk beat during the handshake cycle
    l2_req_ready_i = 1'b1;
    start_miss(6'h2A, 4'b0100);
    chk("b_busy", 256'(busy_o), 256'd1);
    chk("b_l2v",  256'(l2_req_valid_o), 256'd1);
    chk("b_l2idx", 256'(l2_req_idx_o), 256'h2A);
    beat_valid_i = 1'b1; beat_data_i = 64'hEEEE_EEEE_EEEE_EEEE;
    cyc();
    l2_req_ready_i = 1'b0;
    beat(64'h1111_1111_1111_1111, 1'b0);
    beat(64'h2222_2222_2222_2222, 1'b0);
    beat(64'h3333_3333_3333_3333, 1'b0);
    chk("b_nodone_early", 256'(done_o), 256'd0);
    beat(64'h4444_4444_4444_4444, 1'b0);
    exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    #1;
    chk("b_req",  256'(ram_req_o), 256'b0100);
    chk("b_we",   256'(ram_we_o), 256'd1);
    chk("b_addr", 256'(ram_addr_o), 256'h2A);
    chk("b_data", ram_data_o, exp_line);
    chk("b_done", 256'(done_o), 256'd1);
    chk("b_err",  256'(err_o), 256'd0);
`ifdef SARGANTANA_ICACHE_REFILL_FWD_EN
    chk("b_fwdv", 256'(fwd_valid_o), 256'd1);
    chk("b_fwdl", fwd_line_o, exp_line);
`endif
    cyc();
    chk_quiet("b_after");

    // Slow L2: ready after 5 cycles, beats separated by 2 idle cycles
    start_miss(6'h15, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      chk("s_l2v", 256'(l2_req_valid_o), 256'd1);
      chk("s_l2idx", 256'(l2_req_idx_o), 256'h15);
      cyc();
    end
    l2_req_ready_i = 1'b1;
    cyc();
    l2_req_ready_i = 1'b0;
    chk("s_l2v_drop", 256'(l2_req_valid_o), 256'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(); cyc();
      chk("s_gap_nowe", 256'(ram_we_o), 256'd0);
      chk("s_gap_busy", 256'(busy_o), 256'd1);
      beat({8{8'hA0 + 8'(k)}}, 1'b0);
    end
    #1;
    chk("s_req",  256'(ram_req_o), 256'b0001);
    chk("s_addr", 256'(ram_addr_o), 256'h15);
    chk("s_data", ram_data_o, {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                               64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0});
    chk("s_done", 256'(done_o), 256'd1);
    cyc();
    chk_quiet("s_after");

    // Error on beat 2: all beats consumed, no write, err pulse
    l2_req_ready_i = 1'b1;
    start_miss(6'h03, 4'b1000);
    cyc();
    l2_req_ready_i = 1'b0;
    beat(64'h5, 1'b0);
    beat(64'h6, 1'b0);
    beat(64'h7, 1'b1);
    chk("e_busy_mid", 256'(busy_o), 256'd1);
    beat(64'h8, 1'b0);
    #1;
    chk("e_req",  256'(ram_req_o), 256'd0);
    chk("e_we",   256'(ram_we_o), 256'd0);
    chk("e_err",  256'(err_o), 256'd1);
    chk("e_done", 256'(done_o), 256'd0);
    chk("e_busy", 256'(busy_o), 256'd1);
    cyc();
    chk_quiet("e_after");

    // Kill during FILL after beat 1: drain, no write, no pulses
    l2_req_ready_i = 1'b1;
    start_miss(6'h07, 4'b0010);
    cyc();
    l2_req_ready_i = 1'b0;
    beat(64'h9, 1'b0);
    beat(64'hA, 1'b0);
    kill_i = 1'b1;
    beat(64'hB, 1'b0);
    kill_i = 1'b0;
    chk("k_busy_drain", 256'(busy_o), 256'd1);
    beat(64'hC, 1'b0);
    #1;
    chk("k_busy", 256'(busy_o), 256'd1);
    chk("k_req",  256'(ram_req_o), 256'd0);
    chk("k_done", 256'(done_o), 256'd0);
    chk("k_err",  256'(err_o), 256'd0);
    cyc();
    chk_quiet("k_after");

    // Following miss refills normally; also checks the lockout of miss_i
    l2_req_ready_i = 1'b1;
    start_miss(6'h10, 4'b0100);
    cyc();
    l2_req_ready_i = 1'b0;
    miss_i = 1'b1; miss_idx_i = 6'h3F; miss_way_i = 4'b0001;
    beat(64'h0123_4567_89AB_CDEF, 1'b0);
    miss_i = 1'b0;
    beat(64'h1, 1'b0);
    beat(64'h2, 1'b0);
    beat(64'h3, 1'b0);
    #1;
    chk("l_req",  256'(ram_req_o), 256'b0100);
    chk("l_addr", 256'(ram_addr_o), 256'h10);
    chk("l_data", ram_data_o, {64'h3, 64'h2, 64'h1, 64'h0123_4567_89AB_CDEF});
    chk("l_done", 256'(done_o), 256'd1);
    cyc();
    chk_quiet("l_after");

    // Kill in the write cycle itself suppresses the write
    l2_req_ready_i = 1'b1;
    start_miss(6'h20, 4'b1000);
    cyc();
    l2_req_ready_i = 1'b0;
    beat(64'hD0, 1'b0);
    beat(64'hD1, 1'b0);
    beat(64'hD2, 1'b0);
    beat(64'hD3, 1'b0);
    kill_i = 1'b1;
    #1;
    chk("kw_req",  256'(ram_req_o), 256'd0);
    chk("kw_we",   256'(ram_we_o), 256'd0);
    chk("kw_done", 256'(done_o), 256'd0);
    chk("kw_err",  256'(err_o), 256'd0);
    cyc();
    kill_i = 1'b0;
    chk_quiet("kw_after");

    // Reset at beat 2 drops the refill silently
    l2_req_ready_i = 1'b1;
    start_miss(6'h11, 4'b0010);
    cyc();
    l2_req_ready_i = 1'b0;
    beat(64'hF0, 1'b0);
    beat(64'hF1, 1'b0);
    rst_i = 1'b1;
    beat(64'hF2, 1'b0);
    rst_i = 1'b0;
    chk_quiet("r");
    chk("r_l2v",  256'(l2_req_valid_o), 256'd0);
    chk("r_data", ram_data_o, 256'd0);
    beat(64'hF3, 1'b0);
    chk_quiet("r_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
